// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out converter with a valid/ready input
// handshake and a framed serial output (dout_first / dout_last markers).
// A new word may be accepted while the last bit of the previous one is on
// dout, so consecutive words stream out with no idle gap between them.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             flush,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_first,
    output logic             dout_last,
    output logic             busy
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    logic             cnt_last;
    logic             accept;
    logic [WIDTH-1:0] sreg_shifted;

    // Shift one position toward the output end, zero filling the vacated bit.
    generate
        if (MSB_FIRST) begin : g_msb
            assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
        end
    endgenerate

    assign cnt_last = (cnt == LAST);

    // Ready while empty or while the final bit of the current word is out;
    // held low during reset and whenever a flush is requested.
    assign din_ready = reset_n && !flush && ((state == IDLE) || cnt_last);
    assign accept    = din_valid && din_ready;

    // Output decode straight from the state registers, all zero in IDLE.
    assign busy       = (state == SHIFT);
    assign dout_valid = busy;
    assign dout       = busy && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
    assign dout_first = busy && (cnt == '0);
    assign dout_last  = busy && cnt_last;

    // Control FSM with shift register and bit counter; flush overrides accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        sreg  <= din;
                    end
                end
                SHIFT: begin
                    if (!cnt_last) begin
                        cnt  <= cnt + ONE;
                        sreg <= sreg_shifted;
                    end else if (accept) begin
                        cnt  <= '0;
                        sreg <= din;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                        sreg  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    sreg  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives an MSB-first and an LSB-first instance with the
// same stimulus and compares both against a queue-of-expected-bits model.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         flush;

    logic m_ready, m_dout, m_valid, m_first, m_last, m_busy;
    logic l_ready, l_dout, l_valid, l_first, l_last, l_busy;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (m_ready),
        .flush      (flush),
        .dout       (m_dout),
        .dout_valid (m_valid),
        .dout_first (m_first),
        .dout_last  (m_last),
        .busy       (m_busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (l_ready),
        .flush      (flush),
        .dout       (l_dout),
        .dout_valid (l_valid),
        .dout_first (l_first),
        .dout_last  (l_last),
        .busy       (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected serial bit: value plus its framing markers.
    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } sbit_t;

    sbit_t qm[$];
    sbit_t ql[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Compare one instance's outputs with the head of its expected queue.
    task automatic chk_dut(input string pfx, input sbit_t q[$],
                           input logic rdy, input logic d, input logic v,
                           input logic f, input logic l, input logic bz);
        logic  exp_rdy;
        sbit_t h;
        exp_rdy = reset_n && !flush && (q.size() <= 1);
        h       = (q.size() > 0) ? q[0] : '0;
        chk({pfx, "_ready"}, 32'(rdy), 32'(exp_rdy));
        chk({pfx, "_valid"}, 32'(v),   32'(q.size() > 0));
        chk({pfx, "_busy"},  32'(bz),  32'(q.size() > 0));
        chk({pfx, "_dout"},  32'(d),   32'(h.b));
        chk({pfx, "_first"}, 32'(f),   32'(h.f));
        chk({pfx, "_last"},  32'(l),   32'(h.l));
    endtask

    task automatic check_outputs();
        chk_dut("msb", qm, m_ready, m_dout, m_valid, m_first, m_last, m_busy);
        chk_dut("lsb", ql, l_ready, l_dout, l_valid, l_first, l_last, l_busy);
    endtask

    // Reference: the bit on dout leaves each cycle; an accepted word appends
    // its WIDTH bits in serialization order; flush discards everything.
    task automatic model_step(input logic [W-1:0] d, input logic v, input logic f);
        logic acc;
        acc = v && !f && (qm.size() <= 1);
        if (f) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (acc) begin
                for (int i = W - 1; i >= 0; i--)
                    qm.push_back('{b: d[i], f: (i == W - 1), l: (i == 0)});
                for (int i = 0; i < W; i++)
                    ql.push_back('{b: d[i], f: (i == 0), l: (i == W - 1)});
            end
        end
    endtask

    // Called at a falling edge: apply inputs, check, advance one clock.
    task automatic cycle(input logic [W-1:0] d, input logic v, input logic f);
        din       = d;
        din_valid = v;
        flush     = f;
        #1;
        check_outputs();
        @(posedge clk);
        model_step(d, v, f);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        reset_n   = 1'b0;
        din       = 8'hFF;
        din_valid = 1'b1;
        flush     = 1'b0;
        qm.delete();
        ql.delete();
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        din       = '0;
        din_valid = 1'b1;
        flush     = 1'b0;
        #2;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single word A5, then drain.
        cycle(8'hA5, 1'b1, 1'b0);
        repeat (W + 1) cycle(8'h00, 1'b0, 1'b0);

        // Single word 01, then drain.
        cycle(8'h01, 1'b1, 1'b0);
        repeat (W + 1) cycle(8'h00, 1'b0, 1'b0);

        // Back-to-back FF then 00 with valid held high.
        repeat (W) cycle(8'hFF, 1'b1, 1'b0);
        repeat (W) cycle(8'h00, 1'b1, 1'b0);
        repeat (W + 1) cycle(8'h00, 1'b0, 1'b0);

        // Offer a different word mid-shift; it must be ignored.
        cycle(8'hC3, 1'b1, 1'b0);
        repeat (3) cycle(8'hC3, 1'b0, 1'b0);
        cycle(8'h5A, 1'b1, 1'b0);
        repeat (W) cycle(8'h00, 1'b0, 1'b0);

        // Flush at cnt=4 while offering a word.
        cycle(8'h96, 1'b1, 1'b0);
        repeat (4) cycle(8'h00, 1'b0, 1'b0);
        cycle(8'h77, 1'b1, 1'b1);
        repeat (2) cycle(8'h00, 1'b0, 1'b0);

        // Asynchronous reset at cnt=5, then a fresh 3C.
        cycle(8'hE7, 1'b1, 1'b0);
        repeat (5) cycle(8'h00, 1'b0, 1'b0);
        async_reset();
        cycle(8'h3C, 1'b1, 1'b0);
        repeat (W + 1) cycle(8'h00, 1'b0, 1'b0);

        // Randomized traffic: din wanders freely, occasional flushes.
        for (int i = 0; i < 600; i++) begin
            cycle(W'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
        end
        repeat (W + 1) cycle(8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
